// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampled UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        PARITY   = 3'd3,
        STOP     = 3'd4,
        BRK_WAIT = 3'd5
    } rx_state_t;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_VOTE_FIRST = 7;
    localparam int unsigned UART_VOTE_LAST  = 9;
    localparam int unsigned SAMPLE_W        = 4;
    localparam int unsigned DATA_W          = 8;

    // Payload held in the single-entry output register.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              parity_err;
        logic              frame_err;
        logic              brk;
        logic              overrun;
    } rx_word_t;

    // Clocks per sample tick; never below 1 so the tick generator always runs.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned os);
        int unsigned d;
        d = clk_freq / (baud * os);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Sample-tick generator: one-clock pulse every DIV clocks, realignable to a start edge.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned DIV   = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (restart) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CNT_MAX) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_oversampled.sv
// 16x oversampled UART receiver with majority voting, error flags and a
// one-entry valid/ready output register.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RX,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_parity_err,
    output logic              rx_frame_err,
    output logic              rx_break,
    output logic              rx_overrun,
    output logic              UART_Busy
);

    localparam logic [SAMPLE_W-1:0] S_V1  = SAMPLE_W'(UART_VOTE_FIRST);
    localparam logic [SAMPLE_W-1:0] S_V2  = SAMPLE_W'(UART_VOTE_FIRST + 1);
    localparam logic [SAMPLE_W-1:0] S_DEC = SAMPLE_W'(UART_VOTE_LAST);
    localparam logic [SAMPLE_W-1:0] S_END = SAMPLE_W'(UART_OVERSAMPLE - 1);
    localparam logic                ODD   = (PARITY_ODD != 0);
    localparam logic                HAS_P = (PARITY_EN != 0);

    rx_state_t         state;
    logic              rx_meta;
    logic              rx_s;
    logic              tick;
    logic [SAMPLE_W-1:0] sample_cnt;
    logic [3:0]        bit_idx;
    logic              v7;
    logic              v8;
    logic [DATA_W-1:0] rx_shift;
    logic              par_bit;
    logic              parity_err_q;
    rx_word_t          word_q;

    logic              start_edge_c;
    logic              vote_c;
    logic              commit_c;
    rx_word_t          word_c;

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
        end
    end

    assign start_edge_c = (state == IDLE) && !rx_s;
    assign vote_c       = (v7 & v8) | (v7 & rx_s) | (v8 & rx_s);
    assign commit_c     = (state == STOP) && tick && (sample_cnt == S_DEC);

    uart_baud_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(start_edge_c),
        .tick   (tick)
    );

    // Receive FSM; UART_Busy is updated together with every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            UART_Busy    <= 1'b0;
            sample_cnt   <= '0;
            bit_idx      <= '0;
            v7           <= 1'b1;
            v8           <= 1'b1;
            rx_shift     <= '0;
            par_bit      <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (tick && sample_cnt == S_V1) v7 <= rx_s;
            if (tick && sample_cnt == S_V2) v8 <= rx_s;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state        <= START;
                        UART_Busy    <= 1'b1;
                        sample_cnt   <= '0;
                        bit_idx      <= '0;
                        par_bit      <= 1'b0;
                        parity_err_q <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        sample_cnt <= sample_cnt + 1'b1;
                        if (sample_cnt == S_DEC && vote_c) begin
                            state     <= IDLE;
                            UART_Busy <= 1'b0;
                        end else if (sample_cnt == S_END) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        sample_cnt <= sample_cnt + 1'b1;
                        if (sample_cnt == S_DEC) rx_shift[bit_idx[2:0]] <= vote_c;
                        if (sample_cnt == S_END) begin
                            if (bit_idx == 4'd7) state <= HAS_P ? PARITY : STOP;
                            else                 bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        sample_cnt <= sample_cnt + 1'b1;
                        if (sample_cnt == S_DEC) begin
                            par_bit      <= vote_c;
                            parity_err_q <= vote_c != (^rx_shift ^ ODD);
                        end
                        if (sample_cnt == S_END) state <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        sample_cnt <= sample_cnt + 1'b1;
                        if (sample_cnt == S_DEC) begin
                            state     <= vote_c ? IDLE : BRK_WAIT;
                            UART_Busy <= !vote_c;
                        end
                    end
                end
                BRK_WAIT: begin
                    if (rx_s) begin
                        state     <= IDLE;
                        UART_Busy <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    UART_Busy <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        word_c            = '0;
        word_c.data       = rx_shift;
        word_c.parity_err = parity_err_q;
        word_c.frame_err  = !vote_c;
        word_c.brk        = !vote_c && (rx_shift == '0) && (!par_bit || !HAS_P);
        word_c.overrun    = 1'b0;
    end

    // One-entry holding register: a frame arriving while the slot is still
    // owned by the consumer is dropped and only marks the held word overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q   <= '0;
            rx_valid <= 1'b0;
        end else if (commit_c) begin
            if (!rx_valid || rx_ready) begin
                word_q   <= word_c;
                rx_valid <= 1'b1;
            end else begin
                word_q.overrun <= 1'b1;
            end
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

    assign rx_data       = word_q.data;
    assign rx_parity_err = word_q.parity_err;
    assign rx_frame_err  = word_q.frame_err;
    assign rx_break      = word_q.brk;
    assign rx_overrun    = word_q.overrun;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: 16 clocks per bit, 8E1 framing.
module tb_uart_rx_oversampled;

    localparam int unsigned CLK_FREQ   = 1600000;
    localparam int unsigned BAUD_RATE  = 100000;
    localparam int unsigned BIT_CLKS   = 16;
    localparam logic        PARITY_ODD = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       brk;
        logic       ovr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       RX = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       rx_break;
    logic       rx_overrun;
    logic       UART_Busy;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    bit   slot_full = 1'b0;

    uart_rx_oversampled #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .OVERSAMPLE(16),
        .PARITY_EN (1),
        .PARITY_ODD(0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .RX           (RX),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_parity_err(rx_parity_err),
        .rx_frame_err (rx_frame_err),
        .rx_break     (rx_break),
        .rx_overrun   (rx_overrun),
        .UART_Busy    (UART_Busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: what a receiver must report for one frame, from the line bits alone.
    function automatic exp_t ref_word(input logic [7:0] d, input logic p, input logic s);
        exp_t e;
        logic want_p;
        want_p = (($countones(d) % 2) == 1) ^ PARITY_ODD;
        e.data = d;
        e.pe   = (p != want_p);
        e.fe   = !s;
        e.brk  = !s && (d == 8'h00) && !p;
        e.ovr  = 1'b0;
        return e;
    endfunction

    // Holding-slot model: a frame landing on an unaccepted word is dropped.
    task automatic model_commit(input exp_t e);
        exp_t t;
        if (slot_full) begin
            t = exp_q.pop_back();
            t.ovr = 1'b1;
            exp_q.push_back(t);
        end else begin
            exp_q.push_back(e);
            slot_full = !rx_ready;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives start, 8 data bits LSB first, parity, stop; a low stop may be stretched.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int extra_low);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            RX = bits[i];
            repeat (BIT_CLKS) @(posedge clk);
            #1;
        end
        if (!s && extra_low > 0) idle(extra_low);
        RX = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] d);
        logic p;
        p = (($countones(d) % 2) == 1) ^ PARITY_ODD;
        model_commit(ref_word(d, p, 1'b1));
        send_frame(d, p, 1'b1, 0);
    endtask

    task automatic accept();
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        slot_full = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, 32'({rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_break, rx_overrun, UART_Busy}), 32'd0);
    endtask

    // Monitor: a word is checked in the cycle the consumer takes it.
    always @(negedge clk) begin
        if (rst_n && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 32'(rx_data), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("word_data", 32'(rx_data), 32'(e.data));
                chk("word_flags", 32'({rx_parity_err, rx_frame_err, rx_break, rx_overrun}),
                    32'({e.pe, e.fe, e.brk, e.ovr}));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, queue=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("reset_outputs");
        idle(3);
        chk_all_zero("reset_outputs_held");
        rst_n = 1'b1;
        idle(4);
        chk_all_zero("post_reset_idle");

        // Clean 8E1 frame and a parity-error frame.
        send_good(8'hA5);
        idle(6);
        model_commit(ref_word(8'h3C, 1'b1, 1'b1));
        send_frame(8'h3C, 1'b1, 1'b1, 0);
        idle(6);

        // Stop bit low: frame error, line held low keeps the receiver parked.
        model_commit(ref_word(8'h55, 1'b0, 1'b0));
        send_frame(8'h55, 1'b0, 1'b0, 48);
        idle(0);
        RX = 1'b0;
        chk("brk_wait_busy", 32'(UART_Busy), 32'd1);
        RX = 1'b1;
        idle(5);
        chk("brk_wait_exit", 32'(UART_Busy), 32'd0);

        // Line low for 20 bit times gives exactly one break word.
        model_commit(ref_word(8'h00, 1'b0, 1'b0));
        send_frame(8'h00, 1'b0, 1'b0, 9 * BIT_CLKS);
        RX = 1'b0;
        chk("break_busy_while_low", 32'(UART_Busy), 32'd1);
        chk("break_single_word", 32'(rx_valid), 32'd0);
        RX = 1'b1;
        idle(5);
        chk("break_release", 32'(UART_Busy), 32'd0);

        // Six-clock glitch: busy pulses, no word, back to idle quickly.
        RX = 1'b0;
        idle(6);
        RX = 1'b1;
        chk("glitch_busy_pulse", 32'(UART_Busy), 32'd1);
        n = 0;
        while (UART_Busy && n < 10) begin
            idle(1);
            n++;
        end
        chk("glitch_busy_clears", 32'(UART_Busy), 32'd0);
        chk("glitch_no_valid", 32'(rx_valid), 32'd0);
        idle(8);

        // Overrun: three frames with the consumer stalled.
        rx_ready = 1'b0;
        send_good(8'h11);
        idle(6);
        send_good(8'h22);
        idle(6);
        send_good(8'h33);
        idle(6);
        chk("overrun_hold_valid", 32'(rx_valid), 32'd1);
        chk("overrun_hold_data", 32'(rx_data), 32'(exp_q[0].data));
        chk("overrun_flag", 32'(rx_overrun), 32'(exp_q[0].ovr));
        accept();
        idle(2);
        chk("accept_clears_valid", 32'(rx_valid), 32'd0);
        rx_ready = 1'b1;
        send_good(8'h44);
        idle(6);

        // Accept landing in the very cycle the next frame commits.
        rx_ready = 1'b0;
        send_good(8'h11);
        idle(6);
        slot_full = 1'b0;
        model_commit(ref_word(8'h22, 1'b0, 1'b1));
        fork
            send_frame(8'h22, 1'b0, 1'b1, 0);
            begin
                repeat (173) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        idle(4);
        chk("same_cycle_valid", 32'(rx_valid), 32'd1);
        chk("same_cycle_data", 32'(rx_data), 32'(exp_q[0].data));
        accept();
        rx_ready = 1'b1;
        idle(4);

        // Reset in the middle of 0xF0's data bits, then a clean 0x81.
        RX = 1'b0;
        idle(BIT_CLKS);
        idle(3 * BIT_CLKS + 5);
        rst_n = 1'b0;
        RX = 1'b1;
        #1 chk_all_zero("mid_frame_reset");
        idle(3);
        rst_n = 1'b1;
        idle(4);
        chk_all_zero("after_mid_frame_reset");
        send_good(8'h81);
        idle(6);

        // Randomized frames with occasional parity and stop corruption.
        for (int i = 0; i < 24; i++) begin
            logic [7:0] d;
            logic       p;
            logic       s;
            d = 8'($urandom);
            if ($urandom_range(0, 7) == 0) d = 8'h00;
            p = (($countones(d) % 2) == 1) ^ PARITY_ODD;
            if ($urandom_range(0, 3) == 0) p = !p;
            s = ($urandom_range(0, 5) != 0);
            model_commit(ref_word(d, p, s));
            send_frame(d, p, s, 0);
            idle(int'($urandom_range(4, 12)));
        end

        idle(20);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
